// File: rtl/morse_decoder_if.sv
// Mark/space line plus decoded-letter outputs shared by a Morse line source
// (master) and the decoder (slave).
interface morse_decoder_if;
  logic       morse_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       error;
  logic       busy;

  modport master (
    output morse_in,
    input  letter, letter_valid, error, busy
  );

  modport slave (
    input  morse_in,
    output letter, letter_valid, error, busy
  );
endinterface

// File: rtl/morse_decoder.sv
// Morse receiver: times marks/gaps in units of UNIT_CYCLES and decodes letters A-H.
// Define MORSE_SYNC_EN to put a two-flop synchronizer on morse_in (default: one register).
module morse_decoder #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input logic             CLOCK_50,
  input logic             resetn,
  morse_decoder_if.slave  mif
);

  localparam int CNT_W = $clog2(5 * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(5 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(4 * UNIT_CYCLES);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       len_q, len_d;
  logic [3:0]       pat_q, pat_d;
  logic             bad_q, bad_d;
  logic [2:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [3:0]       dec;

  // Returns {hit, letter}; pattern bits are right-aligned, first symbol most significant.
  function automatic logic [3:0] decode(input logic [2:0] len, input logic [3:0] pat);
    case ({len, pat})
      7'b010_0001: decode = {1'b1, 3'd0};
      7'b100_1000: decode = {1'b1, 3'd1};
      7'b100_1010: decode = {1'b1, 3'd2};
      7'b011_0100: decode = {1'b1, 3'd3};
      7'b001_0000: decode = {1'b1, 3'd4};
      7'b100_0010: decode = {1'b1, 3'd5};
      7'b011_0110: decode = {1'b1, 3'd6};
      7'b100_0000: decode = {1'b1, 3'd7};
      default:     decode = 4'b0000;
    endcase
  endfunction

`ifdef MORSE_SYNC_EN
  logic meta_q;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) meta_q <= 1'b0;
    else         meta_q <= mif.morse_in;
  end
  assign s_d = meta_q;
`else
  assign s_d = mif.morse_in;
`endif

  // cnt_q is the number of cycles s_q has held its present level, including this one.
  always_comb begin
    if (s_d != s_q)          cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
  end

  assign dec = decode(len_q, pat_q);

  // Edges are seen one cycle early on s_d so each mark is classified on its own final count.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pat_d    = pat_q;
    bad_d    = bad_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_d) state_d = MARK;
      end
      MARK: begin
        if (!s_d) begin
          state_d = SPACE;
          if (cnt_q > DASH_MAX || len_q == 3'd4) begin
            bad_d = 1'b1;
          end else begin
            pat_d = {pat_q[2:0], (cnt_q >= DASH_MIN)};
            len_d = len_q + 3'd1;
          end
        end
      end
      SPACE: begin
        if (cnt_q == DASH_MIN) begin
          state_d = EMIT;
          if (!bad_q && dec[3]) begin
            letter_d = dec[2:0];
            valid_d  = 1'b1;
          end else begin
            error_d  = 1'b1;
          end
        end else if (s_d) begin
          state_d = MARK;
        end
      end
      EMIT: begin
        len_d   = 3'd0;
        pat_d   = 4'd0;
        bad_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      cnt_q    <= '0;
      len_q    <= 3'd0;
      pat_q    <= 4'd0;
      bad_q    <= 1'b0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      bad_q    <= bad_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign mif.letter       = letter_q;
  assign mif.letter_valid = valid_q;
  assign mif.error        = error_q;
  assign mif.busy         = (state_q == MARK) || (state_q == SPACE);

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side counterpart of the lab Morse encoder: samples a single mark/space line (as driven onto LEDR[0] by the encoder), times each mark and gap in units of `UNIT_CYCLES` clocks, and classifies marks as dots or dashes. It assembles up to four symbols and, on a letter gap, decodes them to one of the letters A–H. The result is reported as a 3-bit code with a one-cycle strobe. It sits alongside the encoder in the top level so a loop-back bench can check encode→decode round trips.

## Interface
- `UNIT_CYCLES`, 25_000_000, clocks per Morse unit (half second at 50 MHz); benches use 3.
- `CLOCK_50`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset (driven from KEY[0]).
- `morse_in`  in  1  line to decode; 1 = mark (light on), 0 = space.
- `letter`  out  3  last decoded letter, A=0 … H=7; reset 0.
- `letter_valid`  out  1  one-cycle strobe, `letter` updated this cycle; reset 0.
- `error`  out  1  one-cycle strobe on an undecodable letter; reset 0.
- `busy`  out  1  high from the first mark of a letter until its strobe; reset 0.

## Operation
- Symbol code: length `len` (0–4), bits `pat[3:0]`, shifted in MSB-first, dash = 1.
- Table: A len2 `01`; B len4 `1000`; C len4 `1010`; D len3 `100`; E len1 `0`; F len4 `0010`; G len3 `110`; H len4 `0000`.
- Level counter `cnt` counts consecutive cycles at the current (sampled) level.
  - It is 1 on the first cycle after a level change.
  - It saturates at 5·UNIT_CYCLES; width is clog2(5·UNIT_CYCLES+1).
- States:
  - IDLE: `len` = 0, waiting for a mark. Space in IDLE never emits.
  - MARK: entered on a rising sample. On the falling sample, classify the mark:
    - `cnt` < 2·UNIT → dot.
    - 2·UNIT ≤ `cnt` ≤ 4·UNIT → dash.
    - `cnt` > 4·UNIT → set the internal `bad` flag.
    - If `len` is already 4, set `bad` instead of shifting.
    - Then go to SPACE.
  - SPACE: a rising sample before `cnt` reaches 2·UNIT is an intra-letter gap; return to MARK.
  - SPACE: when `cnt` reaches 2·UNIT, go to EMIT.
  - EMIT (one cycle):
    - If `bad` is clear and the pattern matches the table, load `letter` and pulse `letter_valid`.
    - Otherwise pulse `error` and leave `letter` unchanged.
    - Clear `len`, `pat` and `bad`; go to IDLE.
- `letter_valid` and `error` are never high together.
- Reset mid-letter discards the partial letter and returns to IDLE. All outputs go to their reset values immediately (asynchronously).

## Timing
- Sample point `s`:
  - With the synchronizer compiled in, `s` = `morse_in` delayed 2 cycles.
  - Without it, `s` = `morse_in` registered once (1 cycle).
- Strobe latency: the strobe is asserted the cycle after `cnt` = 2·UNIT in SPACE, i.e. 2·UNIT+1 cycles after the falling sample of the last mark.
- A mark that is still high at saturation stays in MARK; `bad` is set when it ends.
- `busy` rises on the cycle MARK is first entered and falls together with the strobe.

## Configuration
- `MORSE_SYNC_EN`:
  - Defined: a two-flop synchronizer sits on `morse_in`, for asynchronous sources such as switches or external pins.
  - Undefined: a single register only; `morse_in` must be synchronous to `CLOCK_50`, and all latencies are one cycle shorter.

## Test plan
All scenarios use `UNIT_CYCLES` = 3 with `MORSE_SYNC_EN` defined.
- A: mark 3, space 3, mark 9, space 9 → `letter`=0 and `letter_valid` for 1 cycle, 7 cycles after the last mark falls at the pins; `error`=0.
- B then H back-to-back: first letter, 9-cycle gap, second letter → strobes with 0 then 7; `busy` low between them.
- Overlong mark: 15 cycles high, then space 9 → `error` pulse; `letter` holds its previous value.
- Fifth symbol: five dots, 3-cycle gaps, then space 9 → `error` pulse, no `letter_valid`.
- Reset mid-letter: `resetn` low for 1 cycle between the two marks of A, then a full E → all outputs 0 during reset; single strobe `letter`=4.
- Idle line: `morse_in`=0 for 100 cycles after reset → no strobes; `busy`=0 throughout.
